// File: rtl/controlador_memoria_principal_pkg.sv
// mem_pkg: state encoding and default geometry shared by the main-memory
// controller and the 2-way set-associative cache sitting upstream of it.
package mem_pkg;

    // Default geometry: 4-bit tag + 1-bit index, one 5-bit block per word
    localparam int LARGURA_END_PADRAO   = 5;
    localparam int LARGURA_DADO_PADRAO  = 5;
    localparam int LATENCIA_PADRAO      = 3;

    // Latency counter width; covers LATENCIA in 1..15
    localparam int LARGURA_CONTADOR_LAT = 4;

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA_LEITURA,
        ESPERA_ESCRITA,
        CONCLUIDO
    } estado_t;

endpackage

// File: rtl/controlador_memoria_principal_if.sv
// Cache <-> main-memory bus: level read/write requests, one-cycle pronto.
// master = cache side, slave = memory controller side.
interface controlador_memoria_principal_if #(
    parameter int LARGURA_END  = mem_pkg::LARGURA_END_PADRAO,
    parameter int LARGURA_DADO = mem_pkg::LARGURA_DADO_PADRAO
);

    logic                    solicitacao_de_leitura;
    logic                    solicitacao_de_escrita;
    logic [LARGURA_END-1:0]  endereco;
    logic [LARGURA_DADO-1:0] dado_escrita;
    logic [LARGURA_DADO-1:0] dado_lido;
    logic                    pronto;
    logic                    ocupado;

    modport master (
        output solicitacao_de_leitura,
        output solicitacao_de_escrita,
        output endereco,
        output dado_escrita,
        input  dado_lido,
        input  pronto,
        input  ocupado
    );

    modport slave (
        input  solicitacao_de_leitura,
        input  solicitacao_de_escrita,
        input  endereco,
        input  dado_escrita,
        output dado_lido,
        output pronto,
        output ocupado
    );

endinterface

// File: rtl/controlador_memoria_principal_contador_latencia.sv
// contador_latencia: loadable down-counter with a zero flag, used to time
// the fixed access latency. Holds at zero instead of wrapping.
module contador_latencia #(
    parameter int LARGURA = mem_pkg::LARGURA_CONTADOR_LAT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carregar,
    input  logic               decrementar,
    input  logic [LARGURA-1:0] valor_carga,
    output logic [LARGURA-1:0] valor,
    output logic               zero
);

    logic [LARGURA-1:0] valor_d;
    logic [LARGURA-1:0] valor_q;

    // Next count: load has priority over decrement
    always_comb begin
        valor_d = valor_q;
        if (carregar) begin
            valor_d = valor_carga;
        end else if (decrementar && (valor_q != '0)) begin
            valor_d = valor_q - 1'b1;
        end
    end

    // Count register, cleared by asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;
    assign zero  = (valor_q == '0);

endmodule

// File: rtl/controlador_memoria_principal.sv
// controlador_memoria_principal: main-memory model + access controller
// serving cache refills (reads) and write-backs (writes) with a fixed
// LATENCIA. Optional access counters: define MEM_CONTADORES_ACESSO_EN.
module controlador_memoria_principal
    import mem_pkg::*;
#(
    parameter int LARGURA_END  = mem_pkg::LARGURA_END_PADRAO,
    parameter int LARGURA_DADO = mem_pkg::LARGURA_DADO_PADRAO,
    parameter int LATENCIA     = mem_pkg::LATENCIA_PADRAO
) (
    input  logic                          clock,
    input  logic                          reset,
    controlador_memoria_principal_if.slave barramento
`ifdef MEM_CONTADORES_ACESSO_EN
    ,
    output logic [7:0]                    contador_leituras,
    output logic [7:0]                    contador_escritas
`endif
);

    localparam int PROFUNDIDADE = 2 ** LARGURA_END;
    localparam logic [LARGURA_CONTADOR_LAT-1:0] CARGA_LAT =
        LARGURA_CONTADOR_LAT'(LATENCIA - 1);

    // Power-up content of word i is i (truncated to the data width)
    function automatic logic [LARGURA_DADO-1:0] padrao_inicial(
        input logic [LARGURA_END-1:0] a
    );
        return LARGURA_DADO'(a);
    endfunction

    estado_t                 estado_d,    estado_q;
    logic [LARGURA_END-1:0]  endereco_d,  endereco_q;
    logic [LARGURA_DADO-1:0] dado_d,      dado_q;
    logic [LARGURA_DADO-1:0] dado_lido_d, dado_lido_q;
    logic                    pronto_d,    pronto_q;
    logic                    ocupado_d,   ocupado_q;

    logic                    carregar;
    logic                    decrementar;
    logic                    contador_zero;
    logic [LARGURA_CONTADOR_LAT-1:0] contador_valor;
    logic                    commit_leitura;
    logic                    commit_escrita;
    logic [LARGURA_DADO-1:0] palavra_lida;

    // Storage holds each word XORed with its power-up pattern, so flops that
    // power up cleared read back as mem[i] = i with no init sequence; reset
    // never touches it.
    logic [LARGURA_DADO-1:0] mem_delta_q [PROFUNDIDADE];

    contador_latencia #(
        .LARGURA (LARGURA_CONTADOR_LAT)
    ) u_contador_latencia (
        .clock       (clock),
        .reset       (reset),
        .carregar    (carregar),
        .decrementar (decrementar),
        .valor_carga (CARGA_LAT),
        .valor       (contador_valor),
        .zero        (contador_zero)
    );

    assign palavra_lida = mem_delta_q[endereco_q] ^ padrao_inicial(endereco_q);

    // Next-state and registered-output logic; write wins over read
    always_comb begin
        estado_d       = estado_q;
        endereco_d     = endereco_q;
        dado_d         = dado_q;
        dado_lido_d    = dado_lido_q;
        pronto_d       = 1'b0;
        ocupado_d      = 1'b0;
        carregar       = 1'b0;
        decrementar    = 1'b0;
        commit_leitura = 1'b0;
        commit_escrita = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (barramento.solicitacao_de_escrita) begin
                    endereco_d = barramento.endereco;
                    dado_d     = barramento.dado_escrita;
                    carregar   = 1'b1;
                    ocupado_d  = 1'b1;
                    estado_d   = ESPERA_ESCRITA;
                end else if (barramento.solicitacao_de_leitura) begin
                    endereco_d = barramento.endereco;
                    carregar   = 1'b1;
                    ocupado_d  = 1'b1;
                    estado_d   = ESPERA_LEITURA;
                end
            end
            ESPERA_LEITURA: begin
                if (contador_zero) begin
                    commit_leitura = 1'b1;
                    dado_lido_d    = palavra_lida;
                    pronto_d       = 1'b1;
                    estado_d       = CONCLUIDO;
                end else begin
                    decrementar = 1'b1;
                    ocupado_d   = 1'b1;
                end
            end
            ESPERA_ESCRITA: begin
                if (contador_zero) begin
                    commit_escrita = 1'b1;
                    pronto_d       = 1'b1;
                    estado_d       = CONCLUIDO;
                end else begin
                    decrementar = 1'b1;
                    ocupado_d   = 1'b1;
                end
            end
            CONCLUIDO: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // FSM state, latched request and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            endereco_q  <= '0;
            dado_q      <= '0;
            dado_lido_q <= '0;
            pronto_q    <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            endereco_q  <= endereco_d;
            dado_q      <= dado_d;
            dado_lido_q <= dado_lido_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
        end
    end

    // Backing store write on the commit edge of a write access
    always_ff @(posedge clock) begin
        if (commit_escrita) begin
            mem_delta_q[endereco_q] <= dado_q ^ padrao_inicial(endereco_q);
        end
    end

    assign barramento.dado_lido = dado_lido_q;
    assign barramento.pronto    = pronto_q;
    assign barramento.ocupado   = ocupado_q;

`ifdef MEM_CONTADORES_ACESSO_EN
    logic [7:0] contador_leituras_d, contador_leituras_q;
    logic [7:0] contador_escritas_d, contador_escritas_q;

    // Access counters advance on commit edges and wrap naturally at 8 bits
    always_comb begin
        contador_leituras_d = contador_leituras_q;
        contador_escritas_d = contador_escritas_q;
        if (commit_leitura) begin
            contador_leituras_d = contador_leituras_q + 8'd1;
        end
        if (commit_escrita) begin
            contador_escritas_d = contador_escritas_q + 8'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_leituras_q <= '0;
            contador_escritas_q <= '0;
        end else begin
            contador_leituras_q <= contador_leituras_d;
            contador_escritas_q <= contador_escritas_d;
        end
    end

    assign contador_leituras = contador_leituras_q;
    assign contador_escritas = contador_escritas_q;
`endif

endmodule

// File: tb/tb_controlador_memoria_principal.sv
// Directed bench for controlador_memoria_principal (LATENCIA=3).
// Define MEM_CONTADORES_ACESSO_EN to also check the access counters.
module tb_controlador_memoria_principal;

    localparam int LAT = 3;

    typedef struct {
        logic       escrita;
        logic       perturba;
        logic [4:0] endereco;
        logic [4:0] dado;
        logic [4:0] esperado;
    } vetor_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   exp_leit;
    int   exp_esc;
    logic [4:0] ultimo_lido;
    vetor_t tabela [11];

`ifdef MEM_CONTADORES_ACESSO_EN
    logic [7:0] contador_leituras;
    logic [7:0] contador_escritas;
`endif

    controlador_memoria_principal_if #(
        .LARGURA_END  (5),
        .LARGURA_DADO (5)
    ) bus ();

    controlador_memoria_principal #(
        .LARGURA_END  (5),
        .LARGURA_DADO (5),
        .LATENCIA     (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .barramento (bus)
`ifdef MEM_CONTADORES_ACESSO_EN
        ,
        .contador_leituras (contador_leituras),
        .contador_escritas (contador_escritas)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        total++;
        if (obtido !== esperado) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nome, obtido, esperado);
        end
    endtask

    task automatic chk_contadores(input string nome);
`ifdef MEM_CONTADORES_ACESSO_EN
        chk({nome, "_cnt_leit"}, {24'd0, contador_leituras}, exp_leit % 256);
        chk({nome, "_cnt_esc"}, {24'd0, contador_escritas}, exp_esc % 256);
`else
        if (nome.len() < 0) $display("%s", nome);
`endif
    endtask

    // Waits for pronto, sampling #1 after each edge; returns edges elapsed
    task automatic espera_pronto(input int limite, output int ciclos);
        ciclos = 0;
        while (ciclos <= limite) begin
            @(posedge clock);
            #1;
            ciclos++;
            if (bus.pronto) break;
        end
    endtask

    // One full access from OCIOSO; returns with the FSM back in OCIOSO
    task automatic executa(input string nome, input logic escrita, input logic perturba,
                           input logic [4:0] endereco, input logic [4:0] dado);
        int ciclos;
        @(negedge clock);
        bus.solicitacao_de_escrita = escrita;
        bus.solicitacao_de_leitura = ~escrita;
        bus.endereco               = endereco;
        bus.dado_escrita           = dado;
        @(posedge clock);
        #1;
        chk({nome, "_ocupado"}, {31'd0, bus.ocupado}, 32'd1);
        if (perturba) begin
            bus.endereco     = endereco ^ 5'h01;
            bus.dado_escrita = ~dado;
        end
        espera_pronto(LAT + 6, ciclos);
        chk({nome, "_latencia"}, ciclos, LAT);
        chk({nome, "_ocupado_pronto"}, {31'd0, bus.ocupado}, 32'd0);
        bus.solicitacao_de_escrita = 1'b0;
        bus.solicitacao_de_leitura = 1'b0;
        if (escrita) exp_esc++; else exp_leit++;
        @(posedge clock);
        #1;
        chk({nome, "_pulso_unico"}, {31'd0, bus.pronto}, 32'd0);
    endtask

    initial begin
        int ciclos;
        int vistos;
        total = 0;
        bad   = 0;
        exp_leit = 0;
        exp_esc  = 0;
        ultimo_lido = 5'h00;

        //                escr  pert  end    dado   esperado dado_lido
        tabela[0]  = '{1'b0, 1'b0, 5'h07, 5'h00, 5'h07};
        tabela[1]  = '{1'b1, 1'b0, 5'h03, 5'h1A, 5'h07};
        tabela[2]  = '{1'b0, 1'b0, 5'h03, 5'h00, 5'h1A};
        tabela[3]  = '{1'b0, 1'b0, 5'h04, 5'h00, 5'h04};
        tabela[4]  = '{1'b0, 1'b0, 5'h1F, 5'h00, 5'h1F};
        tabela[5]  = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tabela[6]  = '{1'b1, 1'b0, 5'h1F, 5'h00, 5'h00};
        tabela[7]  = '{1'b0, 1'b0, 5'h1F, 5'h00, 5'h00};
        tabela[8]  = '{1'b1, 1'b1, 5'h0A, 5'h0C, 5'h00};
        tabela[9]  = '{1'b0, 1'b1, 5'h0A, 5'h00, 5'h0C};
        tabela[10] = '{1'b0, 1'b0, 5'h0B, 5'h00, 5'h0B};

        bus.solicitacao_de_leitura = 1'b0;
        bus.solicitacao_de_escrita = 1'b0;
        bus.endereco               = '0;
        bus.dado_escrita           = '0;
        reset = 1'b1;
        #12;
        chk("reset_dado_lido", {27'd0, bus.dado_lido}, 32'd0);
        chk("reset_pronto", {31'd0, bus.pronto}, 32'd0);
        chk("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
        chk_contadores("reset");
        @(negedge clock);
        reset = 1'b0;

        foreach (tabela[i]) begin
            executa($sformatf("vetor%0d", i), tabela[i].escrita, tabela[i].perturba,
                    tabela[i].endereco, tabela[i].dado);
            chk($sformatf("vetor%0d_dado_lido", i), {27'd0, bus.dado_lido},
                {27'd0, tabela[i].esperado});
            chk_contadores($sformatf("vetor%0d", i));
        end
        ultimo_lido = 5'h0B;

        // Both requests: write first, the held read follows LAT+2 edges later
        @(negedge clock);
        bus.solicitacao_de_escrita = 1'b1;
        bus.solicitacao_de_leitura = 1'b1;
        bus.endereco               = 5'h09;
        bus.dado_escrita           = 5'h15;
        espera_pronto(LAT + 6, ciclos);
        chk("simult_escrita_latencia", ciclos, LAT + 1);
        chk("simult_escrita_sem_leitura", {27'd0, bus.dado_lido}, {27'd0, ultimo_lido});
        bus.solicitacao_de_escrita = 1'b0;
        exp_esc++;
        espera_pronto(LAT + 8, ciclos);
        chk("simult_leitura_espacamento", ciclos, LAT + 2);
        chk("simult_leitura_dado", {27'd0, bus.dado_lido}, 32'h15);
        bus.solicitacao_de_leitura = 1'b0;
        exp_leit++;
        chk_contadores("simult");
        @(posedge clock);
        #1;

        // Reset in the middle of a write aborts it asynchronously
        @(negedge clock);
        bus.solicitacao_de_escrita = 1'b1;
        bus.endereco               = 5'h02;
        bus.dado_escrita           = 5'h1F;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("reset_meio_ocupado", {31'd0, bus.ocupado}, 32'd0);
        chk("reset_meio_pronto", {31'd0, bus.pronto}, 32'd0);
        chk("reset_meio_dado_lido", {27'd0, bus.dado_lido}, 32'd0);
        bus.solicitacao_de_escrita = 1'b0;
        exp_leit = 0;
        exp_esc  = 0;
        chk_contadores("reset_meio");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        vistos = 0;
        repeat (LAT + 3) begin
            @(posedge clock);
            #1;
            if (bus.pronto) vistos++;
        end
        chk("reset_meio_sem_pronto", vistos, 0);
        executa("leitura_pos_abort", 1'b0, 1'b0, 5'h02, 5'h00);
        chk("leitura_pos_abort_dado", {27'd0, bus.dado_lido}, 32'h02);
        chk_contadores("pos_abort");

`ifdef MEM_CONTADORES_ACESSO_EN
        // 256 reads from a cleared counter wrap it back to zero
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_leit = 0;
        exp_esc  = 0;
        for (int i = 0; i < 256; i++) begin
            executa("wrap", 1'b0, 1'b0, 5'(i), 5'h00);
        end
        chk("wrap_leituras", {24'd0, contador_leituras}, 32'd0);
        chk("wrap_escritas", {24'd0, contador_escritas}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
